// File: rtl/ir_tx_ctrl.sv
// IR car-remote transmitter: bus or push-button command, periodic/single-shot packet
// trigger, START/SELECT/R/L/B/F carrier bursts. Define IR_TX_STATUS_EN for BUSY/PKT_DONE.
module ir_tx_ctrl #(
  parameter logic [7:0] BASE_ADDR       = 8'h90,
  parameter int         CARRIER_HALF    = 1389,
  parameter int         PERIOD_CYCLES   = 10_000_000,
  parameter int         START_BURSTS    = 88,
  parameter int         SELECT_BURSTS   = 22,
  parameter int         GAP_BURSTS      = 40,
  parameter int         ASSERT_BURSTS   = 44,
  parameter int         DEASSERT_BURSTS = 22
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SWITCH_MODE,
  input  logic [3:0] PUSH_BUTTON,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic       IR_LED
`ifdef IR_TX_STATUS_EN
  ,
  output logic       BUSY,
  output logic       PKT_DONE
`endif
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_BURSTS = max2(max2(max2(START_BURSTS, SELECT_BURSTS),
                                        max2(GAP_BURSTS, ASSERT_BURSTS)), DEASSERT_BURSTS);
  localparam int HALF_W  = max2($clog2(CARRIER_HALF), 1);
  localparam int BURST_W = max2($clog2(MAX_BURSTS), 1);
  localparam int TIMER_W = max2($clog2(PERIOD_CYCLES), 1);

  typedef logic [BURST_W-1:0] burst_t;

  localparam logic [HALF_W-1:0]  HALF_LAST   = HALF_W'(CARRIER_HALF - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(PERIOD_CYCLES - 1);
  localparam burst_t             START_LAST  = burst_t'(START_BURSTS - 1);
  localparam burst_t             SELECT_LAST = burst_t'(SELECT_BURSTS - 1);
  localparam burst_t             GAP_LAST    = burst_t'(GAP_BURSTS - 1);
  localparam burst_t             ASSERT_LAST = burst_t'(ASSERT_BURSTS - 1);
  localparam burst_t             DEASS_LAST  = burst_t'(DEASSERT_BURSTS - 1);

  // Each gap state knows which burst follows it.
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_GAP_SEL, S_SELECT, S_GAP_R, S_RIGHT,
    S_GAP_L, S_LEFT, S_GAP_B, S_BACK, S_GAP_F, S_FWD
  } state_t;

  state_t              state, next_state;
  logic [3:0]          cmd_reg, cmd_sel, snap;
  logic                enable, pending;
  logic [TIMER_W-1:0]  timer;
  logic [HALF_W-1:0]   half_cnt;
  logic                phase;
  burst_t              burst_cnt, burst_last;
  logic                in_burst, state_end, start, trigger, run;
  logic                wr_cmd, wr_ctrl;
  logic                bus_data_unused;

  function automatic burst_t dir_last(input logic bit_set);
    return bit_set ? ASSERT_LAST : DEASS_LAST;
  endfunction

  assign bus_data_unused = ^BUS_DATA[7:4];
  assign wr_cmd  = BUS_WE && !SWITCH_MODE && (BUS_ADDR == BASE_ADDR);
  assign wr_ctrl = BUS_WE && !SWITCH_MODE && (BUS_ADDR == BASE_ADDR + 8'd1);
  assign run     = enable || SWITCH_MODE;
  assign trigger = run && (timer == TIMER_LAST);
  assign start   = (state == S_IDLE) && (trigger || pending);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    burst_last = GAP_LAST;
    in_burst   = 1'b1;
    case (state)
      S_START:  burst_last = START_LAST;
      S_SELECT: burst_last = SELECT_LAST;
      S_RIGHT:  burst_last = dir_last(snap[0]);
      S_LEFT:   burst_last = dir_last(snap[1]);
      S_BACK:   burst_last = dir_last(snap[2]);
      S_FWD:    burst_last = dir_last(snap[3]);
      default:  in_burst   = 1'b0;
    endcase
  end

  assign state_end = (state != S_IDLE) && (half_cnt == HALF_LAST) && phase &&
                     (burst_cnt == burst_last);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start)     next_state = S_START;
      S_START:   if (state_end) next_state = S_GAP_SEL;
      S_GAP_SEL: if (state_end) next_state = S_SELECT;
      S_SELECT:  if (state_end) next_state = S_GAP_R;
      S_GAP_R:   if (state_end) next_state = S_RIGHT;
      S_RIGHT:   if (state_end) next_state = S_GAP_L;
      S_GAP_L:   if (state_end) next_state = S_LEFT;
      S_LEFT:    if (state_end) next_state = S_GAP_B;
      S_GAP_B:   if (state_end) next_state = S_BACK;
      S_BACK:    if (state_end) next_state = S_GAP_F;
      S_GAP_F:   if (state_end) next_state = S_FWD;
      S_FWD:     if (state_end) next_state = S_IDLE;
      default:                  next_state = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= next_state;
  end

  // Carrier counters restart at every state entry and sit at zero in IDLE.
  always_ff @(posedge CLK) begin
    if (RESET || state == S_IDLE || state_end) begin
      half_cnt  <= '0;
      phase     <= 1'b0;
      burst_cnt <= '0;
    end else if (half_cnt == HALF_LAST) begin
      half_cnt <= '0;
      phase    <= ~phase;
      if (phase) burst_cnt <= burst_cnt + 1'b1;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd_reg <= '0;
      enable  <= 1'b0;
      pending <= 1'b0;
      cmd_sel <= '0;
      snap    <= '0;
      timer   <= '0;
      IR_LED  <= 1'b0;
    end else begin
      if (wr_cmd)  cmd_reg <= BUS_DATA[3:0];
      if (wr_ctrl) enable  <= BUS_DATA[0];
      // A start consumes the pending request, merging it with a coincident periodic trigger.
      if (start)                        pending <= 1'b0;
      else if (wr_ctrl && BUS_DATA[1])  pending <= 1'b1;
      cmd_sel <= SWITCH_MODE ? PUSH_BUTTON : cmd_reg;
      if (start) snap <= cmd_sel;
      if (!run || trigger) timer <= '0;
      else                 timer <= timer + 1'b1;
      IR_LED <= in_burst && !phase;
    end
  end

`ifdef IR_TX_STATUS_EN
  assign BUSY = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) PKT_DONE <= 1'b0;
    else       PKT_DONE <= (state == S_FWD) && state_end;
  end
`endif

endmodule

// File: tb/tb_ir_tx_ctrl.sv
// Self-checking bench for ir_tx_ctrl: IR_LED is compared against a waveform built from
// burst counts per packet segment; BUSY/PKT_DONE are checked when IR_TX_STATUS_EN is set.
module tb_ir_tx_ctrl;

  localparam int HALF       = 2;
  localparam int PERIOD     = 2000;
  localparam int START_B    = 8;
  localparam int SELECT_B   = 2;
  localparam int GAP_B      = 4;
  localparam int ASSERT_B   = 4;
  localparam int DEASSERT_B = 2;
  localparam int PKT_LEN_9  = (START_B + SELECT_B + 5 * GAP_B + 2 * ASSERT_B + 2 * DEASSERT_B) * 2 * HALF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       switch_mode = 1'b0;
  logic [3:0] push_button = 4'h0;
  logic [7:0] bus_addr = 8'h00;
  logic [7:0] bus_data = 8'h00;
  logic       bus_we = 1'b0;
  logic       ir_led;
`ifdef IR_TX_STATUS_EN
  logic       busy, pkt_done;
`endif

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  bit exp_q[$];

  ir_tx_ctrl #(
    .BASE_ADDR(8'h90), .CARRIER_HALF(HALF), .PERIOD_CYCLES(PERIOD),
    .START_BURSTS(START_B), .SELECT_BURSTS(SELECT_B), .GAP_BURSTS(GAP_B),
    .ASSERT_BURSTS(ASSERT_B), .DEASSERT_BURSTS(DEASSERT_B)
  ) dut (
    .CLK(clk), .RESET(rst), .SWITCH_MODE(switch_mode), .PUSH_BUTTON(push_button),
    .BUS_ADDR(bus_addr), .BUS_DATA(bus_data), .BUS_WE(bus_we), .IR_LED(ir_led)
`ifdef IR_TX_STATUS_EN
    , .BUSY(busy), .PKT_DONE(pkt_done)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: a packet is a list of (bursts, carrier-on) segments; a carrier burst is HALF high then HALF low.
  function automatic void add_seg(input int bursts, input bit on);
    for (int b = 0; b < bursts; b++)
      for (int c = 0; c < 2 * HALF; c++) exp_q.push_back(on && (c < HALF));
  endfunction

  function automatic void build_packet(input logic [3:0] cmd);
    exp_q.delete();
    add_seg(START_B, 1'b1);
    add_seg(GAP_B, 1'b0);
    add_seg(SELECT_B, 1'b1);
    for (int d = 0; d < 4; d++) begin
      add_seg(GAP_B, 1'b0);
      add_seg(cmd[d] ? ASSERT_B : DEASSERT_B, 1'b1);
    end
  endfunction

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_addr = a; bus_data = d; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int waited, output bit found);
    waited = 0; found = 1'b0;
    while (waited < budget && !found) begin
      @(negedge clk);
      waited++;
      if (ir_led === 1'b1) found = 1'b1;
    end
  endtask

  // Samples n cycles from the first high IR_LED sample; optionally drives one bus write mid-packet.
  task automatic capture(input logic [3:0] cmd, input int n, input int inj_at,
                         input logic [7:0] ia, input logic [7:0] id,
                         output int errs, output int first_bad,
                         output int busy_errs, output int dones);
    build_packet(cmd);
    errs = 0; first_bad = -1; busy_errs = 0; dones = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      if (ir_led !== exp_q[k]) begin
        errs++;
        if (first_bad < 0) first_bad = k;
      end
`ifdef IR_TX_STATUS_EN
      if (k < exp_q.size() - 1 && busy !== 1'b1) busy_errs++;
      if (pkt_done === 1'b1) dones++;
`endif
      if (k == inj_at) begin
        bus_addr = ia; bus_data = id; bus_we = 1'b1;
      end else begin
        bus_we = 1'b0;
      end
    end
    bus_we = 1'b0;
  endtask

  task automatic watch_quiet(input int n, output int highs, output int busy_highs);
    highs = 0; busy_highs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ir_led !== 1'b0) highs++;
`ifdef IR_TX_STATUS_EN
      if (busy !== 1'b0) busy_highs++;
`endif
    end
  endtask

  task automatic test_reset;
    int highs, bh;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (ir_led !== 1'b0) $display("FAIL reset_led: IR_LED=%b, required 0", ir_led);
    else passes++;
    rst = 1'b0;
    watch_quiet(3000, highs, bh);
    checks++;
    if (highs !== 0 || bh !== 0)
      $display("FAIL reset_idle: %0d LED-high and %0d BUSY-high cycles, required 0", highs, bh);
    else passes++;
  endtask

  task automatic test_periodic;
    int waited, errs, fb, be, dn, t0;
    bit found;
    bus_write(8'h90, 8'h09);
    bus_write(8'h91, 8'h01);
    wait_start(PERIOD + 10, waited, found);
    t0 = cyc;
    checks++;
    if (!found || waited < PERIOD || waited > PERIOD + 3)
      $display("FAIL periodic_first: start after %0d cycles (found=%0d), required %0d..%0d", waited, found, PERIOD, PERIOD + 3);
    else passes++;
    capture(4'h9, PKT_LEN_9, -1, 8'h00, 8'h00, errs, fb, be, dn);
    checks++;
    if (errs !== 0) $display("FAIL periodic_wave1: %0d bad cycles (first %0d), required 0", errs, fb);
    else passes++;
`ifdef IR_TX_STATUS_EN
    checks++;
    if (be !== 0 || dn !== 1) $display("FAIL periodic_status: busy_errs=%0d done_pulses=%0d, required 0/1", be, dn);
    else passes++;
`endif
    wait_start(PERIOD, waited, found);
    checks++;
    if (!found || (cyc - t0) !== PERIOD)
      $display("FAIL periodic_period: packet spacing %0d (found=%0d), required %0d", cyc - t0, found, PERIOD);
    else passes++;
    capture(4'h9, PKT_LEN_9, -1, 8'h00, 8'h00, errs, fb, be, dn);
    checks++;
    if (errs !== 0) $display("FAIL periodic_wave2: %0d bad cycles (first %0d), required 0", errs, fb);
    else passes++;
  endtask

  task automatic test_switch_mode;
    int waited, errs, fb, be, dn, highs, bh;
    bit found;
    @(negedge clk);
    switch_mode = 1'b1;
    push_button = 4'b0110;
    bus_write(8'h90, 8'h0F);
    wait_start(PERIOD + 10, waited, found);
    checks++;
    if (!found) $display("FAIL switch_start: no packet within %0d cycles, required one", waited);
    else passes++;
    capture(4'b0110, 4 * HALF * (START_B + SELECT_B + 5 * GAP_B + 2 * ASSERT_B + 2 * DEASSERT_B),
            -1, 8'h00, 8'h00, errs, fb, be, dn);
    checks++;
    if (errs !== 0) $display("FAIL switch_wave: %0d bad cycles (first %0d), required 0", errs, fb);
    else passes++;
    @(negedge clk);
    switch_mode = 1'b0;
    wait_start(PERIOD + 10, waited, found);
    capture(4'h9, PKT_LEN_9, -1, 8'h00, 8'h00, errs, fb, be, dn);
    checks++;
    if (!found || errs !== 0)
      $display("FAIL switch_ignored_write: found=%0d, %0d bad cycles (first %0d), required cmd 0x9 packet", found, errs, fb);
    else passes++;
    bus_write(8'h91, 8'h00);
    watch_quiet(PERIOD + 500, highs, bh);
    checks++;
    if (highs !== 0 || bh !== 0)
      $display("FAIL disable_quiet: %0d LED-high and %0d BUSY-high cycles, required 0", highs, bh);
    else passes++;
  endtask

  task automatic test_single_shot;
    int waited, errs, fb, be, dn, highs, bh;
    bit found;
    bus_write(8'h91, 8'h02);
    wait_start(10, waited, found);
    checks++;
    if (!found || waited > 4) $display("FAIL shot_latency: %0d cycles (found=%0d), required <=4", waited, found);
    else passes++;
    capture(4'h9, PKT_LEN_9, -1, 8'h00, 8'h00, errs, fb, be, dn);
    checks++;
    if (errs !== 0) $display("FAIL shot_wave: %0d bad cycles (first %0d), required 0", errs, fb);
    else passes++;
    watch_quiet(PERIOD + 500, highs, bh);
    checks++;
    if (highs !== 0) $display("FAIL shot_once: %0d LED-high cycles after packet, required 0", highs);
    else passes++;
  endtask

  task automatic test_back_to_back;
    int waited, errs, fb, be, dn, highs, bh;
    bit found;
    bus_write(8'h91, 8'h02);
    wait_start(10, waited, found);
    capture(4'h9, PKT_LEN_9, 50, 8'h91, 8'h02, errs, fb, be, dn);
    checks++;
    if (!found || errs !== 0) $display("FAIL b2b_first: found=%0d, %0d bad cycles (first %0d), required 0", found, errs, fb);
    else passes++;
`ifdef IR_TX_STATUS_EN
    checks++;
    if (be !== 0 || dn !== 1) $display("FAIL b2b_status: busy_errs=%0d done_pulses=%0d, required 0/1", be, dn);
    else passes++;
`endif
    wait_start(6, waited, found);
    checks++;
    if (!found || waited > 4) $display("FAIL b2b_restart: %0d cycles after end (found=%0d), required <=4", waited, found);
    else passes++;
    capture(4'h9, PKT_LEN_9, -1, 8'h00, 8'h00, errs, fb, be, dn);
    checks++;
    if (errs !== 0) $display("FAIL b2b_second: %0d bad cycles (first %0d), required 0", errs, fb);
    else passes++;
    watch_quiet(PERIOD + 500, highs, bh);
    checks++;
    if (highs !== 0) $display("FAIL b2b_quiet: %0d LED-high cycles, required 0", highs);
    else passes++;
  endtask

  task automatic test_cmd_change;
    int waited, errs, fb, be, dn;
    bit found;
    bus_write(8'h91, 8'h02);
    wait_start(10, waited, found);
    capture(4'h9, PKT_LEN_9, 40, 8'h90, 8'h00, errs, fb, be, dn);
    checks++;
    if (!found || errs !== 0) $display("FAIL cmd_change_current: found=%0d, %0d bad cycles (first %0d), required 0", found, errs, fb);
    else passes++;
    repeat (20) @(negedge clk);
    bus_write(8'h91, 8'h02);
    wait_start(10, waited, found);
    capture(4'h0, 4 * HALF * (START_B + SELECT_B + 5 * GAP_B) + 16 * HALF * DEASSERT_B,
            -1, 8'h00, 8'h00, errs, fb, be, dn);
    checks++;
    if (!found || errs !== 0) $display("FAIL cmd_change_next: found=%0d, %0d bad cycles (first %0d), required 0", found, errs, fb);
    else passes++;
  endtask

  task automatic test_random_cmds;
    int waited, errs, fb, be, dn;
    bit found;
    logic [3:0] cmd;
    for (int i = 0; i < 6; i++) begin
      cmd = 4'($urandom_range(0, 15));
      repeat (5) @(negedge clk);
      bus_write(8'h90, {4'($urandom_range(0, 15)), cmd});
      bus_write(8'h91, 8'h02);
      wait_start(10, waited, found);
      checks++;
      if (!found) $display("FAIL rand_start_%0d: no packet within %0d cycles, required one", i, waited);
      else passes++;
      build_packet(cmd);
      capture(cmd, exp_q.size(), -1, 8'h00, 8'h00, errs, fb, be, dn);
      checks++;
      if (errs !== 0) $display("FAIL rand_wave_%0d: cmd 0x%h, %0d bad cycles (first %0d), required 0", i, cmd, errs, fb);
      else passes++;
    end
  endtask

  task automatic test_reset_mid;
    int waited, errs, fb, be, dn, highs, bh;
    bit found;
    repeat (5) @(negedge clk);
    bus_write(8'h90, 8'h09);
    bus_write(8'h91, 8'h03);
    wait_start(10, waited, found);
    // Index 106 falls inside the LEFT burst (START+gap+SELECT+gap+R+gap = 104 cycles).
    capture(4'h9, 107, -1, 8'h00, 8'h00, errs, fb, be, dn);
    checks++;
    if (!found || errs !== 0) $display("FAIL reset_mid_pre: found=%0d, %0d bad cycles (first %0d), required 0", found, errs, fb);
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ir_led !== 1'b0) $display("FAIL reset_mid_led: IR_LED=%b, required 0", ir_led);
    else passes++;
`ifdef IR_TX_STATUS_EN
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_mid_busy: BUSY=%b, required 0", busy);
    else passes++;
`endif
    @(negedge clk);
    rst = 1'b0;
    watch_quiet(PERIOD + 500, highs, bh);
    checks++;
    if (highs !== 0 || bh !== 0)
      $display("FAIL reset_mid_quiet: %0d LED-high and %0d BUSY-high cycles, required 0", highs, bh);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_switch_mode();
    test_single_shot();
    test_back_to_back();
    test_cmd_change();
    test_random_cmds();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
